// File: rtl/xorshift_prng_multi_pkg.sv
// rtl/xorshift_prng_multi_pkg.sv - shared types and defaults for the multi-lane xorshift generator
//
// Contents:
//   state_t        : generator FSM states (unseeded, discarding warm-up steps, producing)
//   SH64_* / SH32_*: well-known full-period shift triples for 64- and 32-bit words
//   DEF_LANE_SALT  : default per-lane seed offset (golden-ratio constant)
//   DEF_ZERO_SUB   : default replacement for an all-zero lane seed
package xorshift_pkg;

    typedef enum logic [1:0] {
        S_UNSEEDED = 2'd0,
        S_WARMUP   = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    localparam int SH64_A = 21;
    localparam int SH64_B = 35;
    localparam int SH64_C = 4;

    localparam int SH32_A = 13;
    localparam int SH32_B = 17;
    localparam int SH32_C = 5;

    localparam logic [63:0] DEF_LANE_SALT = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] DEF_ZERO_SUB  = 64'h0000000000000001;

endpackage

// File: rtl/xorshift_prng_multi_if.sv
// rtl/xorshift_prng_multi_if.sv - seed command and output stream bundle of the xorshift generator
//
// Signals:
//   seed_load  : single-cycle seed load request
//   seed       : WIDTH-bit seed, sampled with seed_load
//   out_data   : LANES*WIDTH output word set, lane i at [i*WIDTH +: WIDTH]
//   out_valid  : out_data holds a fresh word set
//   out_ready  : consumer accepts out_data when out_valid & out_ready
// Modports:
//   master : the generator
//   slave  : the seed source / randomness consumer
interface xorshift_prng_multi_if #(
    parameter int WIDTH = 64,
    parameter int LANES = 2
);
    logic                     seed_load;
    logic [WIDTH-1:0]         seed;
    logic [LANES*WIDTH-1:0]   out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  seed_load,
        input  seed,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport slave (
        output seed_load,
        output seed,
        output out_ready,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/xorshift_prng_multi_step.sv
// rtl/xorshift_prng_multi_step.sv - one combinational xorshift step for a single lane
//
// Ports:
//   x    : current lane state (WIDTH bits)
//   next : state after one left/right/left xorshift round; shifted-out bits are dropped
module xorshift_step #(
    parameter int WIDTH = 64,
    parameter int SH_A  = 21,
    parameter int SH_B  = 35,
    parameter int SH_C  = 4
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] t2;

    always_comb begin
        t1   = x ^ (x << SH_A);
        t2   = t1 ^ (t1 >> SH_B);
        next = t2 ^ (t2 << SH_C);
    end

endmodule

// File: rtl/xorshift_prng_multi.sv
// rtl/xorshift_prng_multi.sv - multi-lane xorshift generator with seed load, warm-up and valid/ready output
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-low reset
//   bus       : seed command and output stream (master side)
//   warming   : high while warm-up steps are being discarded
//   gen_count : accepted output transfers since the last seed load, saturating
module xorshift_prng_multi
    import xorshift_pkg::*;
#(
    parameter int          WIDTH     = 64,
    parameter int          SH_A      = SH64_A,
    parameter int          SH_B      = SH64_B,
    parameter int          SH_C      = SH64_C,
    parameter int          LANES     = 2,
    parameter int          WARMUP    = 4,
    parameter logic [63:0] LANE_SALT = DEF_LANE_SALT,
    parameter logic [63:0] ZERO_SUB  = DEF_ZERO_SUB
) (
    input  logic                   clk,
    input  logic                   rst,
    xorshift_prng_multi_if.master  bus,
    output logic                   warming,
    output logic [31:0]            gen_count
);

    localparam logic [WIDTH-1:0] ZSUB       = ZERO_SUB[WIDTH-1:0];
    localparam logic [7:0]       WARMUP_CNT = 8'(WARMUP);

    state_t                 state_q;
    state_t                 state_d;
    logic [7:0]             cnt_q;
    logic [7:0]             cnt_d;
    logic                   load;
    logic                   step;
    logic                   xfer;

    // All lanes live side by side in one packed register so it can drive
    // out_data directly with no logic after the flops.
    logic [LANES*WIDTH-1:0] lane_q;
    logic [LANES*WIDTH-1:0] lane_seed;
    logic [LANES*WIDTH-1:0] lane_nx;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Lane offsets are compile-time constants: no multiplier is built.
        localparam logic [WIDTH-1:0] OFFS = WIDTH'(64'(i) * LANE_SALT);

        logic [WIDTH-1:0] raw;

        assign raw = bus.seed ^ OFFS;
        // An all-zero state is a fixed point of xorshift, so it is never loaded.
        assign lane_seed[i*WIDTH +: WIDTH] = (raw == '0) ? ZSUB : raw;

        xorshift_step #(
            .WIDTH (WIDTH),
            .SH_A  (SH_A),
            .SH_B  (SH_B),
            .SH_C  (SH_C)
        ) u_step (
            .x    (lane_q[i*WIDTH +: WIDTH]),
            .next (lane_nx[i*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        xfer    = 1'b0;

        if (bus.seed_load) begin
            // A seed load overrides any transfer or warm-up step in this cycle.
            load    = 1'b1;
            cnt_d   = WARMUP_CNT;
            state_d = (WARMUP_CNT == 8'd0) ? S_RUN : S_WARMUP;
        end else begin
            case (state_q)
                S_UNSEEDED: begin
                    state_d = S_UNSEEDED;
                end
                S_WARMUP: begin
                    step  = 1'b1;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.out_ready) begin
                        step = 1'b1;
                        xfer = 1'b1;
                    end
                end
                default: begin
                    state_d = S_UNSEEDED;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_UNSEEDED;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q <= '0;
        end else if (load) begin
            lane_q <= lane_seed;
        end else if (step) begin
            lane_q <= lane_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_count <= 32'd0;
        end else if (load) begin
            gen_count <= 32'd0;
        end else if (xfer && (gen_count != 32'hFFFF_FFFF)) begin
            gen_count <= gen_count + 32'd1;
        end
    end

    assign bus.out_data  = lane_q;
    assign bus.out_valid = (state_q == S_RUN);
    assign warming       = (state_q == S_WARMUP);

endmodule

// File: tb/tb_xorshift_prng_multi.sv
// tb/tb_xorshift_prng_multi.sv - self-checking bench for xorshift_prng_multi
module tb_xorshift_prng_multi;

    localparam logic [63:0] SALT = 64'h9E3779B97F4A7C15;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a: main instance (64-bit, 2 lanes, 4 warm-up steps)
    xorshift_prng_multi_if #(.WIDTH(64), .LANES(2)) bus_a ();
    logic        warming_a;
    logic [31:0] gen_count_a;
    xorshift_prng_multi #(.WIDTH(64), .LANES(2), .WARMUP(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master),
        .warming(warming_a), .gen_count(gen_count_a)
    );

    // b: 64-bit, 1 lane, no warm-up
    xorshift_prng_multi_if #(.WIDTH(64), .LANES(1)) bus_b ();
    logic        warming_b;
    logic [31:0] gen_count_b;
    xorshift_prng_multi #(.WIDTH(64), .LANES(1), .WARMUP(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master),
        .warming(warming_b), .gen_count(gen_count_b)
    );

    // c: 32-bit, 13/17/5, 1 lane, 1 warm-up step
    xorshift_prng_multi_if #(.WIDTH(32), .LANES(1)) bus_c ();
    logic        warming_c;
    logic [31:0] gen_count_c;
    xorshift_prng_multi #(.WIDTH(32), .SH_A(13), .SH_B(17), .SH_C(5), .LANES(1), .WARMUP(1)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c.master),
        .warming(warming_c), .gen_count(gen_count_c)
    );

    int errors = 0;
    int checks = 0;
    logic [127:0] sb_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mstep(input logic [63:0] x, input int w, input int a, input int b, input int c);
        logic [63:0] m;
        logic [63:0] t;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        t = x & m;
        t = (t ^ (t << a)) & m;
        t = t ^ (t >> b);
        t = (t ^ (t << c)) & m;
        return t;
    endfunction

    // Expected output sequence for instance a after loading seed s.
    task automatic sb_load(input logic [63:0] s);
        logic [63:0] l0;
        logic [63:0] l1;
        sb_q.delete();
        l0 = s;
        l1 = s ^ SALT;
        if (l0 == 64'd0) l0 = 64'd1;
        if (l1 == 64'd0) l1 = 64'd1;
        for (int k = 0; k < 4; k++) begin
            l0 = mstep(l0, 64, 21, 35, 4);
            l1 = mstep(l1, 64, 21, 35, 4);
        end
        for (int k = 0; k < 1200; k++) begin
            sb_q.push_back({l1, l0});
            l0 = mstep(l0, 64, 21, 35, 4);
            l1 = mstep(l1, 64, 21, 35, 4);
        end
    endtask

    // Inputs change #1 after posedge; the monitor samples at negedge.
    always @(negedge clk) begin
        if (rst && bus_a.out_valid && bus_a.out_ready && !bus_a.seed_load) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 128'd1, 128'd0);
            end else begin
                chk("a_word", bus_a.out_data, sb_q.pop_front());
                chk("a_lane0_nz", 128'(bus_a.out_data[63:0] != 64'd0), 128'd1);
                chk("a_lane1_nz", 128'(bus_a.out_data[127:64] != 64'd0), 128'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [63:0] s);
        bus_a.seed_load = 1'b1;
        bus_a.seed      = s;
        sb_load(s);
        tick();
        bus_a.seed_load = 1'b0;
    endtask

    // Waits for out_valid on instance a and returns the warming cycles seen.
    task automatic wait_valid_a(output int wcnt);
        int n;
        wcnt = 0;
        n = 0;
        while (!bus_a.out_valid && n < 50) begin
            if (warming_a) wcnt++;
            tick();
            n++;
        end
        if (!bus_a.out_valid) chk("a_valid_timeout", 128'd0, 128'd1);
    endtask

    int wc;

    initial begin
        rst = 1'b0;
        bus_a.seed_load = 1'b0; bus_a.seed = '0; bus_a.out_ready = 1'b0;
        bus_b.seed_load = 1'b0; bus_b.seed = '0; bus_b.out_ready = 1'b0;
        bus_c.seed_load = 1'b0; bus_c.seed = '0; bus_c.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 128'(bus_a.out_valid), 128'd0);
        chk("rst_warming", 128'(warming_a), 128'd0);
        chk("rst_gen_count", 128'(gen_count_a), 128'd0);
        chk("rst_data", bus_a.out_data, 128'd0);
        rst = 1'b1;
        tick();

        // b: no warm-up, seed 1
        bus_b.seed_load = 1'b1; bus_b.seed = 64'd1; bus_b.out_ready = 1'b1;
        tick();
        bus_b.seed_load = 1'b0;
        chk("b_valid", 128'(bus_b.out_valid), 128'd1);
        chk("b_word0", 128'(bus_b.out_data), 128'h1);
        chk("b_gc0", 128'(gen_count_b), 128'd0);
        tick();
        chk("b_word1", 128'(bus_b.out_data), 128'h2200011);
        chk("b_gc1", 128'(gen_count_b), 128'd1);
        tick();
        chk("b_word2", 128'(bus_b.out_data), 128'(mstep(64'h2200011, 64, 21, 35, 4)));
        chk("b_gc2", 128'(gen_count_b), 128'd2);
        bus_b.out_ready = 1'b0;

        // c: 32-bit, one warm-up step, seed 1
        bus_c.seed_load = 1'b1; bus_c.seed = 32'd1;
        tick();
        bus_c.seed_load = 1'b0;
        chk("c_warming", 128'(warming_c), 128'd1);
        chk("c_valid_wu", 128'(bus_c.out_valid), 128'd0);
        tick();
        chk("c_warming_end", 128'(warming_c), 128'd0);
        chk("c_valid", 128'(bus_c.out_valid), 128'd1);
        chk("c_word0", 128'(bus_c.out_data), 128'h00042021);

        // a: zero seed, zero-substitution and 1000 transfers
        bus_a.out_ready = 1'b1;
        load_a(64'd0);
        wait_valid_a(wc);
        chk("a_warm_cycles", 128'(wc), 128'd4);
        chk("a_first_lane0", 128'(bus_a.out_data[63:0]),
            128'(mstep(mstep(mstep(mstep(64'd1, 64, 21, 35, 4), 64, 21, 35, 4), 64, 21, 35, 4), 64, 21, 35, 4)));
        repeat (1000) tick();
        bus_a.out_ready = 1'b0;
        chk("a_gc_1000", 128'(gen_count_a), 128'd1000);

        // a: back-pressure for 10 cycles
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_valid", 128'(bus_a.out_valid), 128'd1);
            chk("bp_data", bus_a.out_data, sb_q[0]);
            chk("bp_gc", 128'(gen_count_a), 128'd1000);
        end
        bus_a.out_ready = 1'b1;
        repeat (5) tick();
        chk("a_gc_1005", 128'(gen_count_a), 128'd1005);

        // a: reload mid-RUN with out_ready high, then again mid-WARMUP
        load_a(64'h0123_4567_89AB_CDEF);
        chk("reload_gc", 128'(gen_count_a), 128'd0);
        chk("reload_warming", 128'(warming_a), 128'd1);
        chk("reload_valid", 128'(bus_a.out_valid), 128'd0);
        tick();
        load_a(64'hDEAD_BEEF_0000_0042);
        chk("rewarm_gc", 128'(gen_count_a), 128'd0);
        wait_valid_a(wc);
        chk("rewarm_cycles", 128'(wc), 128'd4);
        repeat (20) tick();
        chk("a_gc_20", 128'(gen_count_a), 128'd20);

        // a: asynchronous reset between edges during RUN
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 128'(bus_a.out_valid), 128'd0);
        chk("arst_data", bus_a.out_data, 128'd0);
        chk("arst_gc", 128'(gen_count_a), 128'd0);
        sb_q.delete();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_valid", 128'(bus_a.out_valid), 128'd0);
            chk("idle_warming", 128'(warming_a), 128'd0);
        end

        // a: recovery after reset
        load_a(64'd5);
        wait_valid_a(wc);
        chk("recover_cycles", 128'(wc), 128'd4);
        repeat (3) tick();
        bus_a.out_ready = 1'b0;
        tick();
        chk("recover_gc", 128'(gen_count_a), 128'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xorshift_prng_multi.md
Name: xorshift_prng_multi

Overview:
- Parametrised multi-lane xorshift pseudo-random generator; next generation of the single 64-bit xorshift block.
- Adds configurable width and shift triple, LANES independent generators, and an explicit seed-load command.
- Adds zero-seed protection, a warm-up discard phase and a valid/ready output handshake with back-pressure.
- Feeds randomness consumers (masking, sampling units) in the hw_core datapath.

Parameters:
- WIDTH, 64, state/output word width per lane; legal values 32 or 64.
- SH_A, 21, first left-shift amount.
- SH_B, 35, right-shift amount.
- SH_C, 4, second left-shift amount.
- LANES, 2, number of independent generator lanes (1..8).
- WARMUP, 4, number of discarded steps after each seed load (0..255).
- LANE_SALT, 64'h9E3779B97F4A7C15, per-lane seed offset constant (truncated to WIDTH).
- ZERO_SUB, 64'h0000000000000001, substitute for an all-zero lane seed (truncated to WIDTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- seed_load  in  1  single-cycle request to load seed.
- seed  in  WIDTH  seed value, sampled when seed_load=1.
- out_data  out  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds a fresh word set.
- out_ready  in  1  consumer accepts out_data when out_valid&out_ready.
- warming  out  1  high while in the WARMUP state.
- gen_count  out  32  number of accepted output transfers since the last seed load; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset (rst=0, asynchronous): state=UNSEEDED, all lane registers 0, out_valid=0, warming=0, gen_count=0, warm-up counter 0.
- Step function per lane (all widths WIDTH, shifted-out bits discarded):
  - t1 = x ^ (x << SH_A)
  - t2 = t1 ^ (t1 >> SH_B)
  - next = t2 ^ (t2 << SH_C)
- Lane seed: s_i = seed ^ (i * LANE_SALT), product truncated to WIDTH. If s_i == 0, ZERO_SUB is loaded instead. Lane 0 therefore receives seed unchanged unless seed==0.
- States and transitions:
  - UNSEEDED: out_valid=0; lanes hold. seed_load=1 -> load s_i into every lane. Go to WARMUP with counter=WARMUP, or to RUN if WARMUP==0.
  - WARMUP: warming=1, out_valid=0. Each cycle all lanes step and the counter decrements. When the counter reaches 1 and steps, go to RUN. Exactly WARMUP steps are discarded.
  - RUN: out_valid=1, out_data=lane registers. On out_valid&out_ready, all lanes step on that edge and gen_count increments (saturating). If out_ready=0, lanes and out_data hold stable.
- Latency:
  - seed_load sampled at edge T -> with WARMUP==0, out_valid=1 after edge T and the first word equals the loaded seeds.
  - Otherwise out_valid=1 after edge T+WARMUP, and the first word is seed state advanced WARMUP steps.
- seed_load in any state takes priority over everything else: lanes reload, gen_count clears, the FSM restarts as from UNSEEDED.
  - seed_load in RUN together with out_ready: the transfer is not counted; out_valid drops the next cycle if WARMUP>0.
- Async reset mid-warm-up or mid-RUN: immediate return to reset values; the next seed_load is required.
- out_data is registered; there is no combinational path from out_ready to out_data.
- A lane register never holds 0 after a seed load, because the xorshift step preserves nonzero state.

Decomposition:
- Package xorshift_pkg: FSM state enum (UNSEEDED, WARMUP, RUN), default shift triples (64: 21/35/4; 32: 13/17/5), LANE_SALT and ZERO_SUB defaults.
- Sub-module xorshift_step: purely combinational, parameters WIDTH/SH_A/SH_B/SH_C, input x, output next. Instantiated LANES times by generate.
- Top module holds the lane registers, seed derivation, FSM, warm-up counter and gen_count.

Test Plan:
- WIDTH=64, LANES=1, WARMUP=0, seed_load with seed=1, out_ready=1:
  - first word 64'h1, next word 64'h2200011, gen_count increments per cycle.
- WIDTH=32, shifts 13/17/5, WARMUP=1, seed=1:
  - warming high for 1 cycle, then first valid word 32'h00042021.
- seed=0, LANES=2:
  - lane 0 loaded with ZERO_SUB (1); lane 1 loaded with LANE_SALT truncated.
  - no lane ever outputs 0 over 1000 transfers.
- Back-pressure: out_ready held 0 for 10 cycles in RUN:
  - out_data and gen_count frozen, out_valid stays 1.
  - the first transfer after release equals the held word.
- seed_load asserted mid-WARMUP and mid-RUN with out_ready=1:
  - sequence restarts from the new seed, gen_count=0, no double count.
- rst driven low asynchronously between edges during RUN:
  - out_valid=0 and lanes=0 immediately; outputs stay idle until seed_load.
